// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared widths, opcode field positions, fetch FSM encoding and the
//          read-tag record that travels alongside each ROM access.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

   localparam int DATA_W     = 14;
   localparam int ADDR_W     = 12;
   localparam int OPCODE_W   = 4;
   localparam int OPCODE_MSB = DATA_W - 1;
   localparam int OPCODE_LSB = DATA_W - OPCODE_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic              vld;
      logic              epoch;
      logic [ADDR_W-1:0] pc;
   } fetch_tag_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module : fetch_fifo
// Brief  : Synchronous DEPTH-entry prefetch FIFO with flush; flush wins over
//          push/pop. Head entry is visible combinationally on rd_data.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 26
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wr_data,
   output logic [WIDTH-1:0]       rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);

   localparam int c_PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W:0]   r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign empty     = (r_count == '0);
   assign full      = (r_count == DEPTH[c_PTR_W:0]);
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);
   assign rd_data   = r_mem[r_rd_ptr];
   assign count     = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module : fetch_unit
// Brief  : Instruction fetch stage: sequential ROM reads, epoch-tagged returns,
//          prefetch queue, valid/ready to control, redirect flush.
//          Optional same-cycle bypass of returning words: FETCH_BYPASS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit
   import cpu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int ROM_LAT = 1
) (
   input  logic                clk,
   input  logic                reset,
   output logic                rom_rd,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [DATA_W-1:0]   rom_data,
   output logic [DATA_W-1:0]   instr_out,
   output logic [ADDR_W-1:0]   instr_pc,
   output logic [OPCODE_W-1:0] opcode,
   output logic                instr_valid,
   input  logic                instr_ready,
   input  logic                redirect,
   input  logic [ADDR_W-1:0]   redirect_addr,
   input  logic                halt
);

   localparam int              c_CNT_W   = $clog2(DEPTH) + 1;
   localparam int              c_ENT_W   = DATA_W + ADDR_W;
   localparam logic [c_CNT_W:0] c_CREDITS = DEPTH[c_CNT_W:0];

   fetch_state_t       r_state;
   logic [ADDR_W-1:0]  r_pc;
   logic               r_epoch;
   logic [c_CNT_W-1:0] r_inflight;
   fetch_tag_t         r_tag [ROM_LAT];

   logic               w_issue;
   logic               w_ret_any;
   logic               w_ret_ok;
   logic               w_push;
   logic               w_pop;
   logic [c_CNT_W:0]   w_credit_used;
   logic [c_CNT_W-1:0] w_fifo_count;
   logic               w_fifo_empty;
   logic               w_fifo_full;
   logic [c_ENT_W-1:0] w_head;

   // Queued words plus reads still in flight may never exceed the queue size.
   assign w_credit_used = {1'b0, w_fifo_count} + {1'b0, r_inflight};
   assign w_issue       = (r_state == RUN) && !redirect && !w_fifo_full
                          && (w_credit_used < c_CREDITS);
   assign w_ret_any     = r_tag[ROM_LAT-1].vld;
   assign w_ret_ok      = w_ret_any && (r_tag[ROM_LAT-1].epoch == r_epoch) && !redirect;

   assign rom_rd   = w_issue;
   assign rom_addr = r_pc;

`ifdef FETCH_BYPASS_EN
   logic w_bypass;
   assign w_bypass    = w_ret_ok && w_fifo_empty;
   assign instr_valid = !w_fifo_empty || w_bypass;
   assign instr_out   = w_bypass ? rom_data : w_head[c_ENT_W-1:ADDR_W];
   assign instr_pc    = w_bypass ? r_tag[ROM_LAT-1].pc : w_head[ADDR_W-1:0];
   assign w_push      = w_ret_ok && !(w_bypass && instr_ready);
`else
   assign instr_valid = !w_fifo_empty;
   assign instr_out   = w_head[c_ENT_W-1:ADDR_W];
   assign instr_pc    = w_head[ADDR_W-1:0];
   assign w_push      = w_ret_ok;
`endif

   assign w_pop  = instr_ready && !w_fifo_empty;
   assign opcode = instr_out[OPCODE_MSB:OPCODE_LSB];

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (c_ENT_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push    (w_push),
      .pop     (w_pop),
      .flush   (redirect),
      .wr_data ({rom_data, r_tag[ROM_LAT-1].pc}),
      .rd_data (w_head),
      .count   (w_fifo_count),
      .empty   (w_fifo_empty),
      .full    (w_fifo_full)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_pc       <= '0;
         r_epoch    <= 1'b0;
         r_inflight <= '0;
         for (int i = 0; i < ROM_LAT; i++) r_tag[i] <= '0;
      end else begin
         r_inflight <= r_inflight + c_CNT_W'(w_issue) - c_CNT_W'(w_ret_any);
         r_tag[0]   <= {w_issue, r_epoch, r_pc};
         for (int i = 1; i < ROM_LAT; i++) r_tag[i] <= r_tag[i-1];

         // A redirect lands in RUN or HALTED purely by the halt level.
         case (r_state)
            IDLE:    r_state <= RUN;
            RUN:     if (halt) r_state <= HALTED;
            HALTED:  if (!halt) r_state <= RUN;
            default: r_state <= IDLE;
         endcase

         // Toggling the epoch orphans every read still in flight.
         if (redirect) begin
            r_pc    <= redirect_addr;
            r_epoch <= ~r_epoch;
         end else if (w_issue) begin
            r_pc <= r_pc + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module : tb_fetch_unit
// Brief  : Self-checking bench for fetch_unit: startup vector table, scoreboard
//          of issued addresses, stall/redirect/wrap/halt/async-reset sequences.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_unit;
   import cpu_pkg::*;

   localparam int TB_DEPTH = 4;
`ifdef FETCH_BYPASS_EN
   localparam int c_FIRST_V = 2;
`else
   localparam int c_FIRST_V = 3;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              rom_rd;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data = '0;
   logic [DATA_W-1:0] instr_out;
   logic [ADDR_W-1:0] instr_pc;
   logic [OPCODE_W-1:0] opcode;
   logic              instr_valid;
   logic              instr_ready = 1'b0;
   logic              redirect = 1'b0;
   logic [ADDR_W-1:0] redirect_addr = '0;
   logic              halt = 1'b0;

   int errors = 0;
   int checks = 0;

   logic [ADDR_W-1:0] sbq [$];
   logic [ADDR_W-1:0] exp_addr = '0;

   typedef struct {
      logic              ready;
      logic              exp_rd;
      logic [ADDR_W-1:0] exp_addr;
      logic              exp_v;
      logic [ADDR_W-1:0] exp_pc;
      logic [DATA_W-1:0] exp_out;
   } vec_t;
   vec_t vecs [8];

   fetch_unit #(.DEPTH(TB_DEPTH), .ROM_LAT(1)) dut (
      .clk           (clk),
      .reset         (reset),
      .rom_rd        (rom_rd),
      .rom_addr      (rom_addr),
      .rom_data      (rom_data),
      .instr_out     (instr_out),
      .instr_pc      (instr_pc),
      .opcode        (opcode),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .halt          (halt)
   );

   always #5 clk = ~clk;

   // ROM with one cycle of latency: word = address + 0x100
   always @(posedge clk) begin
      if (rom_rd) rom_data <= DATA_W'(rom_addr) + 14'h100;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: record each issued address, compare each accepted word.
   always @(negedge clk) begin
      if (!reset) begin
         sbq.delete();
         exp_addr = '0;
      end else if (redirect) begin
         chk("sb_rd_during_redirect", 32'(rom_rd), 32'd0);
         sbq.delete();
         exp_addr = redirect_addr;
      end else begin
         if (rom_rd) begin
            chk("sb_rom_addr", 32'(rom_addr), 32'(exp_addr));
            sbq.push_back(exp_addr);
            exp_addr = exp_addr + 1'b1;
         end
         if (instr_valid && instr_ready) begin
            if (sbq.size() == 0) begin
               chk("sb_unexpected_word", 32'(instr_pc), 32'hFFFF_FFFF);
            end else begin
               logic [ADDR_W-1:0] e;
               e = sbq.pop_front();
               chk("sb_instr_pc", 32'(instr_pc), 32'(e));
               chk("sb_instr_out", 32'(instr_out), 32'(DATA_W'(e) + 14'h100));
               chk("sb_opcode", 32'(opcode), 32'(instr_out[DATA_W-1:DATA_W-4]));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      instr_ready = 1'b0;
      redirect = 1'b0;
      halt = 1'b0;
      @(negedge clk);
      chk("rst_rom_rd", 32'(rom_rd), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr_out", 32'(instr_out), 32'd0);
      chk("rst_instr_pc", 32'(instr_pc), 32'd0);
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic wait_rd(input string name, output bit found);
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
         @(negedge clk);
         if (rom_rd) found = 1'b1;
         else tick();
      end
      chk(name, 32'(found), 32'd1);
   endtask

   initial begin
      int  n;
      bit  found;
      logic [DATA_W-1:0] held;
      logic [ADDR_W-1:0] wrap_exp [4];

      for (int k = 0; k < 8; k++) begin
         vecs[k].ready    = 1'b1;
         vecs[k].exp_rd   = (k >= 1);
         vecs[k].exp_addr = ADDR_W'(k - 1);
         vecs[k].exp_v    = (k >= c_FIRST_V);
         vecs[k].exp_pc   = ADDR_W'(k - c_FIRST_V);
         vecs[k].exp_out  = DATA_W'(k - c_FIRST_V) + 14'h100;
      end
      wrap_exp[0] = 12'hFFE;
      wrap_exp[1] = 12'hFFF;
      wrap_exp[2] = 12'h000;
      wrap_exp[3] = 12'h001;

      tick();
      do_reset();

      // Startup latency and ordering
      for (int k = 0; k < 8; k++) begin
         instr_ready = vecs[k].ready;
         @(negedge clk);
         chk($sformatf("t1_rom_rd[%0d]", k), 32'(rom_rd), 32'(vecs[k].exp_rd));
         if (vecs[k].exp_rd) chk($sformatf("t1_rom_addr[%0d]", k), 32'(rom_addr), 32'(vecs[k].exp_addr));
         chk($sformatf("t1_valid[%0d]", k), 32'(instr_valid), 32'(vecs[k].exp_v));
         if (vecs[k].exp_v) begin
            chk($sformatf("t1_pc[%0d]", k), 32'(instr_pc), 32'(vecs[k].exp_pc));
            chk($sformatf("t1_out[%0d]", k), 32'(instr_out), 32'(vecs[k].exp_out));
         end
         tick();
      end

      // Back-pressure from empty: exactly DEPTH reads, head held stable
      do_reset();
      n = 0;
      held = '0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (rom_rd) n++;
         if (k == 10) held = instr_out;
         tick();
      end
      chk("stall_reads", 32'(n), 32'(TB_DEPTH));
      @(negedge clk);
      chk("stall_rd_off", 32'(rom_rd), 32'd0);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_head_pc", 32'(instr_pc), 32'd0);
      chk("stall_head_stable", 32'(instr_out), 32'(held));
      tick();
      instr_ready = 1'b1;
      repeat (12) tick();
      chk("stall_resume_progress", 32'(exp_addr > 12'd8), 32'd1);

      // Fill the queue, then async reset mid-cycle
      instr_ready = 1'b0;
      repeat (10) tick();
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_valid", 32'(instr_valid), 32'd0);
      chk("async_rst_rd", 32'(rom_rd), 32'd0);
      tick();
      tick();
      reset = 1'b1;
      instr_ready = 1'b1;
      wait_rd("async_rst_restart", found);
      if (found) chk("async_rst_addr0", 32'(rom_addr), 32'd0);
      tick();

      // Redirect with two queued words and one in flight
      do_reset();
      n = 0;
      for (int k = 0; k < 10 && n < 3; k++) begin
         @(negedge clk);
         if (rom_rd) n++;
         tick();
      end
      chk("redir_setup_reads", 32'(n), 32'd3);
      redirect = 1'b1;
      redirect_addr = 12'h3A0;
      tick();
      redirect = 1'b0;
      instr_ready = 1'b1;
      @(negedge clk);
      chk("redir_valid_after", 32'(instr_valid), 32'd0);
      chk("redir_rd", 32'(rom_rd), 32'd1);
      chk("redir_addr", 32'(rom_addr), 32'h3A0);
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         tick();
         @(negedge clk);
         if (instr_valid) begin
            found = 1'b1;
            chk("redir_first_pc", 32'(instr_pc), 32'h3A0);
         end
      end
      chk("redir_first_seen", 32'(found), 32'd1);
      tick();

      // Redirect near the top of the address space, free-running
      repeat (3) tick();
      redirect = 1'b1;
      redirect_addr = 12'hFFE;
      tick();
      redirect = 1'b0;
      n = 0;
      for (int k = 0; k < 20 && n < 4; k++) begin
         @(negedge clk);
         if (instr_valid && instr_ready) begin
            chk($sformatf("wrap_pc[%0d]", n), 32'(instr_pc), 32'(wrap_exp[n]));
            n++;
         end
         tick();
      end
      chk("wrap_count", 32'(n), 32'd4);

      // Halt during steady fetch: reads stop, queue drains
      repeat (4) tick();
      halt = 1'b1;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k >= 1 && rom_rd) n++;
         if (k == 9) chk("halt_drained", 32'(instr_valid), 32'd0);
         tick();
      end
      chk("halt_reads", 32'(n), 32'd0);
      halt = 1'b0;
      wait_rd("halt_resume", found);
      tick();
      repeat (8) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
